// File: rtl/balance_seq.sv
// Run-state sequencer for the balance controller: arms on a power request, paces the sample
// strobe and latches faults. Define BALANCE_SEQ_WDOG_EN to compile in the sample watchdog.
module balance_seq #(
  parameter int unsigned ARM_SAMPLES = 8,
  parameter int unsigned TF_LIMIT    = 4,
  parameter int unsigned WDOG_CYC    = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pwr_req,
  input  logic       ptch_vld,
  input  logic       rider_off,
  input  logic       too_fast,
  input  logic       en_steer_req,
  output logic       vld_out,
  output logic       pwr_up,
  output logic       en_steer,
  output logic       fault,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_ARM    = 3'd1,
    S_RUN    = 3'd2,
    S_SHUTDN = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  localparam logic [7:0] ARM_TARGET = 8'(ARM_SAMPLES);
  localparam logic [3:0] TF_TARGET  = 4'(TF_LIMIT);

  state_t     state_q, state_d;
  logic       pwr_req_q, rise_q;
  logic [7:0] arm_cnt_q, arm_cnt_d;
  logic [3:0] tf_cnt_q, tf_cnt_d;
  logic       wdog_trip;
  logic       live_d;

  // NOTE: clocked blocks use non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwr_req_q <= 1'b1;  // a request already high at reset release is not an edge
      rise_q    <= 1'b0;
    end else begin
      pwr_req_q <= pwr_req;
      rise_q    <= pwr_req & ~pwr_req_q;
    end
  end

`ifdef BALANCE_SEQ_WDOG_EN
  localparam logic [12:0] WDOG_TERM = 13'(WDOG_CYC);
  logic [12:0] wdog_q, wdog_d;

  // Counts idle cycles between samples while armed or running; zero everywhere else.
  always_comb begin
    wdog_d = '0;
    if ((state_q == S_ARM || state_q == S_RUN) && !ptch_vld)
      wdog_d = (wdog_q == WDOG_TERM) ? wdog_q : wdog_q + 13'd1;
  end

  assign wdog_trip = (wdog_d == WDOG_TERM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wdog_q <= '0;
    else        wdog_q <= wdog_d;
  end
`else
  // No watchdog in this build; the tie-off keeps the shared parameter list referenced.
  assign wdog_trip = 1'b0 & (WDOG_CYC != 0);
`endif

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    arm_cnt_d = arm_cnt_q;
    tf_cnt_d  = tf_cnt_q;
    unique case (state_q)
      S_OFF: begin
        if (rise_q) begin
          state_d   = S_ARM;
          arm_cnt_d = '0;
          tf_cnt_d  = '0;
        end
      end
      S_ARM: begin
        if (ptch_vld && arm_cnt_q != 8'hFF) arm_cnt_d = arm_cnt_q + 8'd1;
        if (wdog_trip)                                state_d = S_FAULT;
        else if (!pwr_req)                            state_d = S_SHUTDN;
        else if (ptch_vld && arm_cnt_d >= ARM_TARGET) state_d = S_RUN;
      end
      S_RUN: begin
        if (ptch_vld) begin
          if (!too_fast)              tf_cnt_d = '0;
          else if (tf_cnt_q != 4'hF)  tf_cnt_d = tf_cnt_q + 4'd1;
        end
        if (wdog_trip)                  state_d = S_FAULT;
        else if (tf_cnt_d >= TF_TARGET) state_d = S_FAULT;
        else if (!pwr_req)              state_d = S_SHUTDN;
      end
      S_SHUTDN: begin
        // A departing rider wins over a returning request.
        if (ptch_vld && rider_off) state_d = S_OFF;
        else if (pwr_req)          state_d = S_RUN;
      end
      S_FAULT: begin
        if (!pwr_req) state_d = S_OFF;
      end
      default: state_d = S_OFF;
    endcase
  end

  // Outputs are registered from the next state so they change on the same edge as state.
  assign live_d = (state_d == S_ARM) || (state_d == S_RUN) || (state_d == S_SHUTDN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_OFF;
      arm_cnt_q <= '0;
      tf_cnt_q  <= '0;
      pwr_up    <= 1'b0;
      vld_out   <= 1'b0;
      en_steer  <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state_q   <= state_d;
      arm_cnt_q <= arm_cnt_d;
      tf_cnt_q  <= tf_cnt_d;
      pwr_up    <= live_d;
      vld_out   <= ptch_vld & live_d;
      en_steer  <= (state_d == S_RUN) & en_steer_req & ~rider_off;
      fault     <= (state_d == S_FAULT);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_balance_seq.sv
// Self-checking bench for balance_seq: vector table, directed corner sequences and a
// randomized run against a cycle-level reference model.
module tb_balance_seq;

  localparam int ARM_N  = 8;
  localparam int TF_N   = 4;
  localparam int WDOG_N = 100;
`ifdef BALANCE_SEQ_WDOG_EN
  localparam bit WDOG_ON = 1'b1;
`else
  localparam bit WDOG_ON = 1'b0;
`endif

  localparam int OFF = 0, ARM = 1, RUN = 2, SHUTDN = 3, FLT = 4;

  logic       clk = 1'b0;
  logic       rst_n, pwr_req, ptch_vld, rider_off, too_fast, en_steer_req;
  logic       vld_out, pwr_up, en_steer, fault;
  logic [2:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  balance_seq #(.ARM_SAMPLES(ARM_N), .TF_LIMIT(TF_N), .WDOG_CYC(WDOG_N)) dut (
    .clk(clk), .rst_n(rst_n), .pwr_req(pwr_req), .ptch_vld(ptch_vld),
    .rider_off(rider_off), .too_fast(too_fast), .en_steer_req(en_steer_req),
    .vld_out(vld_out), .pwr_up(pwr_up), .en_steer(en_steer), .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  // Reference model: mode plus plain integer counters, advanced once per clock edge.
  int m_state, m_arm, m_tf, m_idle, m_pu, m_vo, m_es, m_ft;
  bit m_req_d1, m_rise;

  task automatic model_reset();
    m_state = OFF; m_arm = 0; m_tf = 0; m_idle = 0;
    m_pu = 0; m_vo = 0; m_es = 0; m_ft = 0;
    m_req_d1 = 1'b1; m_rise = 1'b0;
  endtask

  task automatic model_step();
    int nxt, arm_n, tf_n, idle_n;
    bit rise, live;
    nxt  = m_state;
    rise = m_rise;
    m_rise   = pwr_req && !m_req_d1;
    m_req_d1 = pwr_req;
    case (m_state)
      OFF: if (rise) begin nxt = ARM; m_arm = 0; m_tf = 0; m_idle = 0; end
      ARM, RUN: begin
        arm_n  = m_arm;
        tf_n   = m_tf;
        idle_n = ptch_vld ? 0 : m_idle + 1;
        if (m_state == ARM && ptch_vld) arm_n = (m_arm < 255) ? m_arm + 1 : 255;
        if (m_state == RUN && ptch_vld) tf_n = too_fast ? ((m_tf < 15) ? m_tf + 1 : 15) : 0;
        if (WDOG_ON && idle_n >= WDOG_N)                      nxt = FLT;
        else if (m_state == RUN && tf_n >= TF_N)              nxt = FLT;
        else if (!pwr_req)                                    nxt = SHUTDN;
        else if (m_state == ARM && ptch_vld && arm_n >= ARM_N) nxt = RUN;
        m_arm = arm_n; m_tf = tf_n; m_idle = idle_n;
      end
      SHUTDN: begin
        m_idle = 0;
        if (ptch_vld && rider_off) nxt = OFF;
        else if (pwr_req)          nxt = RUN;
      end
      default: begin
        m_idle = 0;
        if (!pwr_req) nxt = OFF;
      end
    endcase
    live    = (nxt == ARM) || (nxt == RUN) || (nxt == SHUTDN);
    m_state = nxt;
    m_pu    = int'(live);
    m_vo    = int'(ptch_vld && live);
    m_es    = int'(nxt == RUN && en_steer_req && !rider_off);
    m_ft    = int'(nxt == FLT);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_in(input logic rq, input logic pv, input logic ro, input logic tf,
                        input logic er);
    pwr_req = rq; ptch_vld = pv; rider_off = ro; too_fast = tf; en_steer_req = er;
  endtask

  typedef struct {
    logic       rq, pv, ro, tf, er;
    logic [2:0] st;
    logic       pu, vo, es, ft;
  } vec_t;

  function automatic vec_t v(input logic rq, input logic pv, input logic ro, input logic tf,
                             input logic er, input logic [2:0] st, input logic pu,
                             input logic vo, input logic es, input logic ft);
    vec_t r;
    r.rq = rq; r.pv = pv; r.ro = ro; r.tf = tf; r.er = er;
    r.st = st; r.pu = pu; r.vo = vo; r.es = es; r.ft = ft;
    return r;
  endfunction

  vec_t vecs[12];
  int   tf_pat[8] = '{1, 1, 1, 0, 1, 1, 1, 1};

  initial begin
    // Each row: inputs held for one edge, then the expected registered outputs.
    vecs[0]  = v(1, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0);  // req high through reset: no arm
    vecs[1]  = v(1, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0);
    vecs[2]  = v(0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0);
    vecs[3]  = v(1, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0);  // edge register stage
    vecs[4]  = v(1, 0, 0, 0, 0, 3'd1, 1, 0, 0, 0);  // ARM two cycles after the rise
    vecs[5]  = v(1, 1, 0, 0, 1, 3'd1, 1, 1, 0, 0);
    vecs[6]  = v(1, 0, 0, 0, 1, 3'd1, 1, 0, 0, 0);
    vecs[7]  = v(0, 0, 0, 0, 0, 3'd3, 1, 0, 0, 0);  // request dropped while arming
    vecs[8]  = v(0, 1, 0, 0, 0, 3'd3, 1, 1, 0, 0);
    vecs[9]  = v(0, 1, 1, 0, 0, 3'd0, 0, 0, 0, 0);  // rider gone -> OFF, strobe blocked
    vecs[10] = v(1, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0);
    vecs[11] = v(1, 0, 0, 0, 0, 3'd1, 1, 0, 0, 0);

    rst_n = 1'b0;
    set_in(1, 0, 0, 0, 0);
    model_reset();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    check("reset_state", 32'(state), 0);
    check("reset_pwr_up", 32'(pwr_up), 0);
    check("reset_vld_out", 32'(vld_out), 0);
    check("reset_en_steer", 32'(en_steer), 0);
    check("reset_fault", 32'(fault), 0);

    for (int i = 0; i < 12; i++) begin
      set_in(vecs[i].rq, vecs[i].pv, vecs[i].ro, vecs[i].tf, vecs[i].er);
      tick();
      check($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].st));
      check($sformatf("vec%0d_pwr_up", i), 32'(pwr_up), 32'(vecs[i].pu));
      check($sformatf("vec%0d_vld_out", i), 32'(vld_out), 32'(vecs[i].vo));
      check($sformatf("vec%0d_en_steer", i), 32'(en_steer), 32'(vecs[i].es));
      check($sformatf("vec%0d_fault", i), 32'(fault), 32'(vecs[i].ft));
    end

    // Arming: eight samples, fifty cycles apart; RUN on the eighth.
    set_in(1, 0, 0, 0, 1);
    for (int p = 1; p <= ARM_N; p++) begin
      repeat (49) tick();
      check($sformatf("arm%0d_en_before", p), 32'(en_steer), 0);
      ptch_vld = 1'b1;
      tick();
      ptch_vld = 1'b0;
      check($sformatf("arm%0d_state", p), 32'(state), (p == ARM_N) ? RUN : ARM);
      check($sformatf("arm%0d_vld_out", p), 32'(vld_out), 1);
      check($sformatf("arm%0d_en_steer", p), 32'(en_steer), (p == ARM_N) ? 1 : 0);
      tick();
      check($sformatf("arm%0d_vld_low", p), 32'(vld_out), 0);
    end

    // Overspeed: 3 hot, 1 cool, then 4 hot -> FAULT only on the last.
    for (int i = 0; i < 8; i++) begin
      repeat (4) tick();
      ptch_vld = 1'b1;
      too_fast = tf_pat[i][0];
      tick();
      ptch_vld = 1'b0;
      too_fast = 1'b0;
      check($sformatf("tf%0d_state", i), 32'(state), (i == 7) ? FLT : RUN);
    end
    check("tf_fault", 32'(fault), 1);
    check("tf_pwr_up", 32'(pwr_up), 0);
    check("tf_vld_out", 32'(vld_out), 0);
    check("tf_en_steer", 32'(en_steer), 0);

    // FAULT holds while the request stays high, strobe stays blocked.
    repeat (5) tick();
    ptch_vld = 1'b1;
    tick();
    ptch_vld = 1'b0;
    check("fault_hold_vld", 32'(vld_out), 0);
    repeat (4) tick();
    check("fault_hold_state", 32'(state), FLT);
    pwr_req = 1'b0;
    tick();
    check("fault_exit_state", 32'(state), OFF);
    check("fault_exit_fault", 32'(fault), 0);
    pwr_req = 1'b1;
    tick();
    tick();
    check("rearm_state", 32'(state), ARM);
    // Arm count restarted: seven samples leave it armed, the eighth runs.
    for (int p = 1; p <= ARM_N; p++) begin
      repeat (2) tick();
      ptch_vld = 1'b1;
      tick();
      ptch_vld = 1'b0;
      if (p >= ARM_N - 1)
        check($sformatf("rearm%0d_state", p), 32'(state), (p == ARM_N) ? RUN : ARM);
    end

    // Shutdown path.
    pwr_req = 1'b0;
    tick();
    check("shdn_state", 32'(state), SHUTDN);
    check("shdn_pwr_up", 32'(pwr_up), 1);
    check("shdn_en_steer", 32'(en_steer), 0);
    ptch_vld = 1'b1;
    tick();
    ptch_vld = 1'b0;
    check("shdn_rider_on_state", 32'(state), SHUTDN);
    check("shdn_rider_on_vld", 32'(vld_out), 1);
    pwr_req = 1'b1;
    tick();
    check("shdn_resume_run", 32'(state), RUN);
    pwr_req = 1'b0;
    tick();
    rider_off = 1'b1;
    ptch_vld = 1'b1;
    tick();
    ptch_vld = 1'b0;
    rider_off = 1'b0;
    check("shdn_off_state", 32'(state), OFF);
    check("shdn_off_pwr_up", 32'(pwr_up), 0);

    // Watchdog: last sample at the RUN entry edge, then silence.
    pwr_req = 1'b1;
    tick();
    tick();
    for (int p = 1; p <= ARM_N; p++) begin
      tick();
      ptch_vld = 1'b1;
      tick();
      ptch_vld = 1'b0;
    end
    check("wdog_run_entry", 32'(state), RUN);
    repeat (WDOG_N - 1) tick();
    check("wdog_before_limit", 32'(state), RUN);
    tick();
    check("wdog_at_limit", 32'(state), WDOG_ON ? FLT : RUN);
    repeat (50) tick();
    check("wdog_after_limit", 32'(state), WDOG_ON ? FLT : RUN);

    // Asynchronous reset mid-operation, released with the request still high.
    #2 rst_n = 1'b0;
    #1;
    check("areset_state", 32'(state), OFF);
    check("areset_pwr_up", 32'(pwr_up), 0);
    check("areset_fault", 32'(fault), 0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) tick();
    check("areset_no_arm", 32'(state), OFF);

    // Randomized run against the reference model.
    begin
      int gap = 0;
      for (int c = 0; c < 3000; c++) begin
        if ($urandom_range(99) == 0) pwr_req = ~pwr_req;
        ptch_vld     = ($urandom_range(3) == 0) || (gap >= 60);
        gap          = ptch_vld ? 0 : gap + 1;
        too_fast     = $urandom_range(1) == 1;
        rider_off    = $urandom_range(4) == 0;
        en_steer_req = $urandom_range(9) < 7;
        tick();
        check("rand_state", 32'(state), m_state);
        check("rand_pwr_up", 32'(pwr_up), m_pu);
        check("rand_vld_out", 32'(vld_out), m_vo);
        check("rand_en_steer", 32'(en_steer), m_es);
        check("rand_fault", 32'(fault), m_ft);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/balance_seq.md
# balance_seq

Run-state sequencer for the balance control datapath. Drives its `pwr_up` and enable inputs, and paces its sample strobe `vld`. Takes the power request, the inertial sample strobe, `rider_off` and `too_fast`. Produces the gated sample strobe, `pwr_up` and `en_steer` for the balance controller, plus a latched `fault` for the top level. Sits between the auth/inertial front end and the balance controller.

## Interface
- `ARM_SAMPLES`, 8: valid samples required in ARM before entering RUN (1..255).
- `TF_LIMIT`, 4: consecutive too_fast samples that trip FAULT (1..15).
- `WDOG_CYC`, 4096: max clk cycles between ptch_vld pulses in ARM/RUN (2..8191).
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `pwr_req` in 1: level power request from auth block.
- `ptch_vld` in 1: one-cycle pulse, new inertial sample.
- `rider_off` in 1: rider-absent flag.
- `too_fast` in 1: overspeed flag from balance datapath; sampled only on ptch_vld.
- `en_steer_req` in 1: steering enable request.
- `vld_out` out 1: gated sample strobe to balance controller.
- `pwr_up` out 1: power-up to balance controller.
- `en_steer` out 1: qualified steering enable.
- `fault` out 1: latched fault indicator.
- `state` out 3: current state encoding, for debug.

## Operation
- States and encoding: OFF=0, ARM=1, RUN=2, SHUTDN=3, FAULT=4.
- OFF
  - pwr_up=0.
  - On a pwr_req rising edge (registered previous value 0, current 1) -> ARM; clear arm_cnt, tf_cnt and wdog.
- ARM
  - pwr_up=1, en_steer=0.
  - Each ptch_vld increments arm_cnt (8-bit).
  - When arm_cnt reaches ARM_SAMPLES on a ptch_vld -> RUN.
- RUN
  - pwr_up=1; en_steer = en_steer_req & ~rider_off, registered.
  - On ptch_vld: if too_fast, tf_cnt++ (4-bit, saturating); else tf_cnt=0.
  - tf_cnt reaching TF_LIMIT -> FAULT.
- SHUTDN
  - Entered from ARM or RUN when pwr_req=0.
  - pwr_up=1, en_steer=0.
  - Exits to OFF on the first ptch_vld with rider_off=1.
  - pwr_req returning to 1 -> RUN, without re-arming.
- FAULT
  - pwr_up=0, en_steer=0, fault=1.
  - Stays until pwr_req=0; then -> OFF and fault clears on the OFF entry edge.
- vld_out
  - Registered ptch_vld in ARM, RUN and SHUTDN.
  - Forced to 0 in OFF and FAULT.
- Priority in one cycle: watchdog trip > TF trip > pwr_req=0 > arm completion.
- Counters never wrap:
  - arm_cnt saturates at 255.
  - tf_cnt saturates at 15.
  - wdog saturates at its terminal value.

## Timing
- All outputs are registered. Reset values: state=OFF, pwr_up=0, vld_out=0, en_steer=0, fault=0. All counters reset to 0.
- vld_out latency: 1 cycle after ptch_vld, pulse width 1.
- State transitions take effect on the clk edge after the triggering input. Outputs follow the new state the same cycle as the state register.
- pwr_req rising edge to pwr_up=1: 2 cycles (1 for edge register, 1 for state).
- ptch_vld that completes ARM: its vld_out is still issued, and RUN is active on the same edge.
- Watchdog timing:
  - wdog counts clk cycles in ARM/RUN and clears on every ptch_vld.
  - Reaching WDOG_CYC -> FAULT on the next edge.
  - wdog is held at 0 in OFF, SHUTDN and FAULT.
- ptch_vld coincident with a FAULT transition: vld_out=0.
- rst_n asserted mid-operation returns to OFF asynchronously. Deassertion with pwr_req already high does not arm; an edge is required.

## Configuration
- `BALANCE_SEQ_WDOG_EN` defined:
  - Watchdog counter (13-bit) and its trip path are compiled in, as described above.
- `BALANCE_SEQ_WDOG_EN` undefined:
  - No watchdog counter. Missing ptch_vld never causes FAULT.
  - WDOG_CYC is ignored.
  - All other behaviour is identical.

## Test plan
- Reset with pwr_req=1 held -> state=0, pwr_up=0. Then drop and raise pwr_req -> pwr_up=1 2 cycles after the rise, state=1.
- In ARM, issue 8 ptch_vld pulses every 50 cycles -> state=2 on the 8th pulse. vld_out mirrors each pulse with 1-cycle delay. en_steer=0 until RUN with en_steer_req=1 and rider_off=0.
- In RUN, assert too_fast for 3 samples, clear it for 1, then assert it for 4 -> FAULT only on the 4th consecutive sample. fault=1, pwr_up=0, vld_out stays 0.
- In RUN, drop pwr_req with rider_off=0 -> SHUTDN with pwr_up=1. Set rider_off=1 and pulse ptch_vld -> OFF, pwr_up=0.
- With `BALANCE_SEQ_WDOG_EN` and WDOG_CYC=100, stop ptch_vld in RUN -> FAULT 100 cycles after the last pulse. Without the macro -> remains in RUN.
- In FAULT, hold pwr_req=1 -> stays in FAULT. Drop pwr_req -> OFF, fault=0. Raise pwr_req -> ARM with arm_cnt=0.
